// File: rtl/hack_alu.sv
// Hack-style 16-bit ALU with registered result and zero/negative flags.
// One clock of latency from in_valid to out_valid; no state beyond the output registers.
module hack_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng,
  output logic        out_valid
);

  logic [15:0] xa, xb, ya, yb, r, o;

  always_comb begin
    xa = zx ? 16'h0000 : x;
    xb = nx ? ~xa : xa;
    ya = zy ? 16'h0000 : y;
    yb = ny ? ~ya : ya;
    // Sum truncates to 16 bits: carry-out is intentionally dropped.
    r  = f ? (xb + yb) : (xb & yb);
    o  = no ? ~r : r;
  end

  // Flags are registered alongside out so they always describe the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= 16'h0000;
      zr        <= 1'b1;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= o;
      zr        <= (o == 16'h0000);
      ng        <= o[15];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hack_alu.sv
// Randomised and directed bench for hack_alu: stimulus pushes one expected entry per cycle,
// a negedge monitor pops and compares, covering valid results, held outputs and reset.
module tb_hack_alu;

  logic        clk = 1'b0;
  logic        reset, in_valid;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] out;
  logic        zr, ng, out_valid;

  int checks = 0;
  int failures = 0;

  typedef enum logic [1:0] {E_IDLE, E_VALID, E_RESET} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] res;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] heldOut;

  hack_alu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out), .zr(zr), .ng(ng), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference written from the arithmetic rules: bitwise NOT of a 16-bit value is 65535 - v.
  function automatic logic [15:0] refAlu(input logic [15:0] xv, input logic [15:0] yv,
                                         input logic [5:0] c);
    int unsigned a, b, r;
    a = c[5] ? 0 : int'(xv);
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : int'(yv);
    if (c[2]) b = 65535 - b;
    r = c[1] ? ((a + b) % 65536) : (a & b);
    if (c[0]) r = 65535 - r;
    return r[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [15:0] xv,
                               input logic [15:0] yv, input logic [5:0] ctl,
                               input logic [15:0] expOut);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst; in_valid = vld; x = xv; y = yv;
    {zx, nx, zy, ny, f, no} = ctl;
    e.res = expOut;
    if (rst)      e.kind = E_RESET;
    else if (vld) e.kind = E_VALID;
    else          e.kind = E_IDLE;
    sbq.push_back(e);
  endtask

  task automatic applyOp(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] ctl);
    applyStimulus(1'b0, 1'b1, xv, yv, ctl, refAlu(xv, yv, ctl));
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, $urandom, $urandom, 6'($urandom), 16'h0000);
  endtask

  // Monitor: one scoreboard entry describes the DUT outputs one cycle after it was issued.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      case (e.kind)
        E_RESET: begin
          heldOut = 16'h0000;
          checkOutput("reset_valid", {15'b0, out_valid}, 16'h0000);
        end
        E_VALID: begin
          heldOut = e.res;
          checkOutput("result_valid", {15'b0, out_valid}, 16'h0001);
        end
        default: checkOutput("idle_valid", {15'b0, out_valid}, 16'h0000);
      endcase
      checkOutput("out", out, heldOut);
      checkOutput("zr", {15'b0, zr}, {15'b0, heldOut == 16'h0000});
      checkOutput("ng", {15'b0, ng}, {15'b0, heldOut[15]});
    end
  end

  logic [5:0] canon [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
  };

  typedef struct {
    logic [15:0] xv, yv;
    logic [5:0]  ctl;
    logic [15:0] res;
  } dir_t;

  // Hand-derived results for the directed cases.
  dir_t directed [19] = '{
    '{16'h0000, 16'hFFFF, 6'b101010, 16'h0000},
    '{16'h0000, 16'hFFFF, 6'b111111, 16'h0001},
    '{16'h0000, 16'hFFFF, 6'b111010, 16'hFFFF},
    '{16'h0000, 16'hFFFF, 6'b000010, 16'hFFFF},
    '{16'h0000, 16'hFFFF, 6'b000000, 16'h0000},
    '{16'h0000, 16'hFFFF, 6'b010101, 16'hFFFF},
    '{16'h0000, 16'hFFFF, 6'b001111, 16'h0000},
    '{16'h0000, 16'hFFFF, 6'b110111, 16'h0000},
    '{16'h0011, 16'h0003, 6'b000010, 16'h0014},
    '{16'h0011, 16'h0003, 6'b010011, 16'h000E},
    '{16'h0011, 16'h0003, 6'b000111, 16'hFFF2},
    '{16'h0011, 16'h0003, 6'b000000, 16'h0001},
    '{16'h0011, 16'h0003, 6'b010101, 16'h0013},
    '{16'h0011, 16'h0003, 6'b001101, 16'hFFEE},
    '{16'h0011, 16'h0003, 6'b110011, 16'hFFFD},
    '{16'h0011, 16'h0003, 6'b001110, 16'h0010},
    '{16'h0011, 16'h0003, 6'b110111, 16'h0004},
    '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000},
    '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000}
  };

  initial begin
    reset = 1'b1; in_valid = 1'b0; x = '0; y = '0;
    {zx, nx, zy, ny, f, no} = 6'b0;
    heldOut = 16'h0000;

    applyStimulus(1'b1, 1'b1, 16'd17, 16'd0, 6'b001100, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'd17, 16'd0, 6'b001100, 16'h0000);
    applyIdle();
    applyOp(16'd17, 16'd5, 6'b001100);
    applyIdle();

    foreach (directed[i])
      applyStimulus(1'b0, 1'b1, directed[i].xv, directed[i].yv, directed[i].ctl, directed[i].res);

    foreach (canon[i]) applyOp(16'h0000, 16'hFFFF, canon[i]);
    foreach (canon[i]) applyOp(16'h0011, 16'h0003, canon[i]);

    for (int i = 0; i < 4; i++) applyOp($urandom, $urandom, canon[$urandom_range(0, 17)]);
    for (int i = 0; i < 3; i++) applyIdle();

    for (int i = 0; i < 3; i++) applyOp($urandom, $urandom, 6'($urandom));
    applyStimulus(1'b1, 1'b1, $urandom, $urandom, 6'($urandom), 16'h0000);
    applyIdle();
    applyOp(16'h1234, 16'h4321, 6'b000010);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) applyIdle();
      else                           applyOp($urandom, $urandom, 6'($urandom));
    end
    applyIdle();

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
